// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Optional retire counter is enabled with CU_PERF_CNT_EN (see top).
package cu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
  } state_t;

  typedef enum logic [1:0] {
    MEM_NONE,
    MEM_STORE,
    MEM_LOAD
  } mem_t;

  localparam logic [1:0] OP_BRANCH  = 2'b00;
  localparam logic [1:0] OP_ILLEGAL = 2'b01;
  localparam logic [1:0] OP_MEM     = 2'b10;
  localparam logic [1:0] OP_ALU     = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_CMP = 3'b001;
  localparam logic [2:0] ALU_ILL = 3'b111;

  localparam logic [1:0] EXT_NONE = 2'b00;
  localparam logic [1:0] EXT_MEM  = 2'b01;
  localparam logic [1:0] EXT_IMM  = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction handshake and memory strobe/ack bundle of the control unit.
interface multicycle_control_unit_if;
  logic       instr_valid;
  logic [1:0] op;
  logic [1:0] inst;
  logic       immin;
  logic       flush;
  logic       mem_ack;
  logic       instr_ready;
  logic       wmem;
  logic       rmem;

  modport master (
    output instr_valid, op, inst, immin, flush, mem_ack,
    input  instr_ready, wmem, rmem
  );

  modport slave (
    input  instr_valid, op, inst, immin, flush, mem_ack,
    output instr_ready, wmem, rmem
  );
endinterface

// File: rtl/multicycle_control_unit_field_decode.sv
// Combinational decode of latched {op, inst, immin} into ALU function,
// immediate-extend select, memory access type and illegal flag.
module cu_field_decode
  import cu_pkg::*;
(
  input  logic [1:0] i_op,
  input  logic [1:0] i_inst,
  input  logic       i_immin,
  output logic [2:0] o_alu_ctrl,
  output logic [1:0] o_ext_sel,
  output mem_t       o_mem_type,
  output logic       o_illegal
);

  always_comb begin
    o_alu_ctrl = ALU_ILL;
    o_mem_type = MEM_NONE;
    o_illegal  = 1'b0;
    case (i_op)
      OP_ALU:    o_alu_ctrl = {1'b0, i_inst};
      OP_BRANCH: o_alu_ctrl = ALU_CMP;
      OP_MEM: begin
        o_alu_ctrl = ALU_ADD;
        // Immediate forms of 00/01 and inst=10 are address computations only
        if (i_inst == 2'b11)                   o_illegal  = 1'b1;
        else if (!i_immin && i_inst == 2'b00)  o_mem_type = MEM_STORE;
        else if (!i_immin && i_inst == 2'b01)  o_mem_type = MEM_LOAD;
      end
      default: begin
        o_alu_ctrl = ALU_ILL;
        o_illegal  = 1'b1;
      end
    endcase
  end

  always_comb begin
    o_ext_sel = EXT_NONE;
    if (i_immin) o_ext_sel = (i_op == OP_MEM) ? EXT_MEM : EXT_IMM;
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Five-state multicycle control unit (IDLE/DECODE/EXEC/MEM/WB) with memory
// wait timeout. Define CU_PERF_CNT_EN to add the 32-bit o_retired_cnt output.
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  multicycle_control_unit_if.slave  cu_bus,
  output logic                      o_wreg,
  output logic                      o_wpc,
  output logic [1:0]                o_jmpF,
  output logic [2:0]                o_alu_ctrl,
  output logic [1:0]                o_ext_sel,
  output logic                      o_retire,
  output logic                      o_err
`ifdef CU_PERF_CNT_EN
  ,
  output logic [31:0]               o_retired_cnt
`endif
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_op;
  logic [1:0]       r_inst;
  logic             r_immin;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0]       w_alu_ctrl;
  logic [1:0]       w_ext_sel;
  mem_t             w_mem_type;
  logic             w_illegal;
  logic             w_wmem;
  logic             w_rmem;
  logic             w_wreg;
  logic             w_wpc;
  logic             w_retire;
  logic             w_err;
  logic             w_active;

  cu_field_decode u_field_decode (
    .i_op       (r_op),
    .i_inst     (r_inst),
    .i_immin    (r_immin),
    .o_alu_ctrl (w_alu_ctrl),
    .o_ext_sel  (w_ext_sel),
    .o_mem_type (w_mem_type),
    .o_illegal  (w_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_inst  <= '0;
      r_immin <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && cu_bus.instr_valid && !cu_bus.flush) begin
        r_op    <= cu_bus.op;
        r_inst  <= cu_bus.inst;
        r_immin <= cu_bus.immin;
      end
      if (r_state != ST_MEM)
        r_cnt <= '0;
      else if (!cu_bus.mem_ack && r_cnt != LIMIT)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_wmem   = 1'b0;
    w_rmem   = 1'b0;
    w_wreg   = 1'b0;
    w_wpc    = 1'b0;
    w_retire = 1'b0;
    w_err    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cu_bus.instr_valid && !cu_bus.flush) w_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_illegal) begin
          w_err  = 1'b1;
          w_next = ST_IDLE;
        end else if (cu_bus.flush) begin
          w_next = ST_IDLE;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cu_bus.flush) begin
          w_next = ST_IDLE;
        end else begin
          case (r_op)
            OP_BRANCH: begin
              w_wpc    = 1'b1;
              w_retire = 1'b1;
              w_next   = ST_IDLE;
            end
            OP_MEM:  w_next = ST_MEM;
            OP_ALU:  w_next = ST_WB;
            default: w_next = ST_IDLE;
          endcase
        end
      end
      ST_MEM: begin
        // Counter at LIMIT marks the abort cycle: strobes already dropped, ack ignored
        if (r_cnt == LIMIT && w_mem_type != MEM_NONE) begin
          w_err  = 1'b1;
          w_next = ST_IDLE;
        end else begin
          case (w_mem_type)
            MEM_STORE: begin
              w_wmem = 1'b1;
              if (cu_bus.mem_ack) begin
                w_retire = 1'b1;
                w_next   = ST_IDLE;
              end
            end
            MEM_LOAD: begin
              w_rmem = 1'b1;
              if (cu_bus.mem_ack) w_next = ST_WB;
            end
            default: w_next = ST_WB;
          endcase
        end
      end
      ST_WB: begin
        if (!cu_bus.flush) begin
          w_wreg   = 1'b1;
          w_retire = 1'b1;
        end
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_active           = (r_state != ST_IDLE);
  assign cu_bus.instr_ready = (r_state == ST_IDLE);
  assign cu_bus.wmem        = w_wmem;
  assign cu_bus.rmem        = w_rmem;
  assign o_wreg             = w_wreg;
  assign o_wpc              = w_wpc;
  assign o_retire           = w_retire && !rst;
  assign o_err              = w_err && !rst;
  assign o_jmpF             = w_active ? r_inst : '0;
  assign o_alu_ctrl         = w_active ? w_alu_ctrl : '0;
  assign o_ext_sel          = w_active ? w_ext_sel : '0;

`ifdef CU_PERF_CNT_EN
  logic [31:0] r_retired_cnt;

  always_ff @(posedge clk) begin
    if (rst)           r_retired_cnt <= '0;
    else if (w_retire) r_retired_cnt <= r_retired_cnt + 32'd1;
  end

  assign o_retired_cnt = r_retired_cnt;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit (TIMEOUT_CYCLES=4).
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        wreg, wpc, retire, err;
  logic [1:0]  jmpF, ext_sel;
  logic [2:0]  alu_ctrl;
`ifdef CU_PERF_CNT_EN
  logic [31:0] retired_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct packed {
    logic [31:0] cyc;
    logic        wreg, wpc, wmem, rmem, retire, err;
    logic [2:0]  alu;
    logic [1:0]  ext;
    logic [1:0]  jmp;
  } ev_t;

  ev_t exp_q[$];

  multicycle_control_unit_if cu_bus();

  multicycle_control_unit #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cu_bus     (cu_bus),
    .o_wreg     (wreg),
    .o_wpc      (wpc),
    .o_jmpF     (jmpF),
    .o_alu_ctrl (alu_ctrl),
    .o_ext_sel  (ext_sel),
    .o_retire   (retire),
    .o_err      (err)
`ifdef CU_PERF_CNT_EN
    ,
    .o_retired_cnt (retired_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s act=%h req=%h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: every cycle with any strobe/pulse is matched against the queue.
  always @(negedge clk) begin
    ev_t act;
    ev_t e;
    act = '{cyc: cyc, wreg: wreg, wpc: wpc, wmem: cu_bus.wmem, rmem: cu_bus.rmem,
            retire: retire, err: err, alu: alu_ctrl, ext: ext_sel, jmp: jmpF};
    if (wreg === 1'b1 || wpc === 1'b1 || cu_bus.wmem === 1'b1 || cu_bus.rmem === 1'b1 ||
        retire === 1'b1 || err === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_event act=%h", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          n_fail++;
          $display("FAIL event act=%h req=%h (cyc/wreg,wpc,wmem,rmem,ret,err/alu/ext/jmp)", act, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int c, input logic [5:0] s, input logic [2:0] alu,
                      input logic [1:0] ext, input logic [1:0] jmp);
    exp_q.push_back('{cyc: c, wreg: s[5], wpc: s[4], wmem: s[3], rmem: s[2],
                      retire: s[1], err: s[0], alu: alu, ext: ext, jmp: jmp});
  endtask

  // Returns the accept cycle; caller is left at the cycle after accept.
  task automatic issue(input logic [1:0] op, input logic [1:0] inst, input logic immin,
                       output int a);
    int w;
    w = 0;
    while (cu_bus.instr_ready !== 1'b1 && w < 50) begin
      tick(1);
      w++;
    end
    if (w >= 50) chk("ready_wait_timeout", 32'(w), 32'd0);
    cu_bus.instr_valid = 1'b1;
    cu_bus.op          = op;
    cu_bus.inst        = inst;
    cu_bus.immin       = immin;
    a = cyc;
    tick(1);
    cu_bus.instr_valid = 1'b0;
  endtask

  // strobe order in push: {wreg, wpc, wmem, rmem, retire, err}
  initial begin
    int a;
    rst                = 1'b1;
    cu_bus.instr_valid = 1'b0;
    cu_bus.op          = '0;
    cu_bus.inst        = '0;
    cu_bus.immin       = 1'b0;
    cu_bus.flush       = 1'b0;
    cu_bus.mem_ack     = 1'b0;
    tick(3);
    rst = 1'b0;
    chk("reset_ready", 32'(cu_bus.instr_ready), 32'd1);
    chk("reset_outputs", 32'({wreg, wpc, cu_bus.wmem, cu_bus.rmem, retire, err,
                              alu_ctrl, ext_sel, jmpF}), 32'd0);
`ifdef CU_PERF_CNT_EN
    chk("perf_cnt_reset", retired_cnt, 32'd0);
`endif

    // ALU op=11 inst=10: wreg/retire at a+3, ready back at a+4
    issue(2'b11, 2'b10, 1'b0, a);
    push(a + 3, 6'b100010, 3'b010, 2'b00, 2'b10);
    tick(1);
    chk("alu_exec_ctrl", 32'(alu_ctrl), 32'h2);
    tick(1);
    chk("alu_ready_busy", 32'(cu_bus.instr_ready), 32'd0);
    tick(1);
    chk("alu_ready_back", 32'(cu_bus.instr_ready), 32'd1);

    // ALU immediate with stray mem_ack held high throughout
    cu_bus.mem_ack = 1'b1;
    issue(2'b11, 2'b01, 1'b1, a);
    push(a + 3, 6'b100010, 3'b001, 2'b10, 2'b01);
    tick(3);
    cu_bus.mem_ack = 1'b0;

    // Branch: wpc/retire at a+2
    issue(2'b00, 2'b11, 1'b1, a);
    push(a + 2, 6'b010010, 3'b001, 2'b10, 2'b11);
    tick(2);
    chk("branch_ready", 32'(cu_bus.instr_ready), 32'd1);

    // Store, ack on first MEM cycle (a+3)
    issue(2'b10, 2'b00, 1'b0, a);
    push(a + 3, 6'b001010, 3'b000, 2'b00, 2'b00);
    tick(2);
    cu_bus.mem_ack = 1'b1;
    tick(1);
    cu_bus.mem_ack = 1'b0;
    chk("store_ready", 32'(cu_bus.instr_ready), 32'd1);

    // Load, ack on third MEM cycle: rmem a+3..a+5, wreg a+6
    issue(2'b10, 2'b01, 1'b0, a);
    push(a + 3, 6'b000100, 3'b000, 2'b00, 2'b01);
    push(a + 4, 6'b000100, 3'b000, 2'b00, 2'b01);
    push(a + 5, 6'b000100, 3'b000, 2'b00, 2'b01);
    push(a + 6, 6'b100010, 3'b000, 2'b00, 2'b01);
    tick(4);
    cu_bus.mem_ack = 1'b1;
    tick(1);
    cu_bus.mem_ack = 1'b0;
    tick(1);
    chk("load_ready", 32'(cu_bus.instr_ready), 32'd1);

    // Store timeout: wmem a+3..a+6, err a+7, no retire
    issue(2'b10, 2'b00, 1'b0, a);
    push(a + 3, 6'b001000, 3'b000, 2'b00, 2'b00);
    push(a + 4, 6'b001000, 3'b000, 2'b00, 2'b00);
    push(a + 5, 6'b001000, 3'b000, 2'b00, 2'b00);
    push(a + 6, 6'b001000, 3'b000, 2'b00, 2'b00);
    push(a + 7, 6'b000001, 3'b000, 2'b00, 2'b00);
    tick(7);
    chk("timeout_ready", 32'(cu_bus.instr_ready), 32'd1);

    // Illegal classes: err in DECODE
    issue(2'b01, 2'b00, 1'b0, a);
    push(a + 1, 6'b000001, 3'b111, 2'b00, 2'b00);
    tick(1);
    chk("illegal_op_ready", 32'(cu_bus.instr_ready), 32'd1);
    issue(2'b10, 2'b11, 1'b0, a);
    push(a + 1, 6'b000001, 3'b000, 2'b00, 2'b11);
    tick(1);
    chk("illegal_mem_ready", 32'(cu_bus.instr_ready), 32'd1);

    // Flush in EXEC of branch: no wpc, no retire
    issue(2'b00, 2'b10, 1'b0, a);
    tick(1);
    cu_bus.flush = 1'b1;
    tick(1);
    cu_bus.flush = 1'b0;
    chk("flush_exec_ready", 32'(cu_bus.instr_ready), 32'd1);

    // flush with instr_valid in IDLE: not accepted
    cu_bus.instr_valid = 1'b1;
    cu_bus.flush       = 1'b1;
    cu_bus.op          = 2'b11;
    tick(1);
    cu_bus.instr_valid = 1'b0;
    cu_bus.flush       = 1'b0;
    chk("flush_idle_no_accept", 32'(cu_bus.instr_ready), 32'd1);
    tick(4);

    // Address-compute mem form: silent MEM a+3, wreg a+4
    issue(2'b10, 2'b10, 1'b1, a);
    push(a + 4, 6'b100010, 3'b000, 2'b01, 2'b10);
    tick(4);
    chk("addr_op_ready", 32'(cu_bus.instr_ready), 32'd1);

    // rst during MEM of load (sampled end of a+4)
    issue(2'b10, 2'b01, 1'b0, a);
    push(a + 3, 6'b000100, 3'b000, 2'b00, 2'b01);
    push(a + 4, 6'b000100, 3'b000, 2'b00, 2'b01);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst_mem_rmem", 32'(cu_bus.rmem), 32'd0);
    chk("rst_mem_ready", 32'(cu_bus.instr_ready), 32'd1);
`ifdef CU_PERF_CNT_EN
    chk("perf_cnt_after_rst", retired_cnt, 32'd0);
`endif

    for (int i = 0; i < 3; i++) begin
      issue(2'b11, 2'(i), 1'b0, a);
      push(a + 3, 6'b100010, {1'b0, 2'(i)}, 2'b00, 2'(i));
      tick(3);
    end
`ifdef CU_PERF_CNT_EN
    chk("perf_cnt_three", retired_cnt, 32'd3);
`endif

    tick(5);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
